// File: rtl/prime_power_gen_if.sv
// Purpose : valid/ready stream carrying prime powers from prime_power_gen to the product stage.
// Latency : none (wires only).
// Backpressure: a beat transfers when out_valid & out_ready; the master holds out_data/out_last while stalled.
// Signals : out_valid/out_data/out_last driven by master, out_ready driven by slave.
interface prime_power_gen_if #(
    parameter int WIDTH = 32
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/prime_power_gen.sv
// Purpose : streams, in ascending prime order, the largest power p^k <= n for every prime p <= n.
// Latency : data dependent; one divisor test or one multiply per cycle, plus one beat per prime.
// Backpressure: out_data/out_last are held while out_valid & !out_ready; the search stalls meanwhile.
// Ports   : clk, rst_n (async active-low), start/n (request, sampled in IDLE/DONE),
//           out_if (master stream: out_valid/out_ready/out_data/out_last), busy, done, count.
// Option  : define PRIME_POWER_LCM_EN to add the lcm output (running product of transferred beats).
module prime_power_gen #(
    parameter int NW    = 8,
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NW-1:0]     n,
    prime_power_gen_if.master out_if,
    output logic              busy,
    output logic              done,
`ifdef PRIME_POWER_LCM_EN
    output logic [WIDTH-1:0]  lcm,
`endif
    output logic [NW-1:0]     count
);
    localparam int W2 = 2 * NW;
    localparam int LW = NW + 1;   // lookahead candidate may step one past lim

    typedef enum logic [2:0] {IDLE, TEST, POWER, EMIT, DONE} state_t;

    state_t          state;
    logic [NW-1:0]   lim;
    logic [NW-1:0]   c;
    logic [NW-1:0]   d;
    logic [NW-1:0]   pw;
    logic [LW-1:0]   lc;   // lookahead candidate used to decide out_last
    logic [NW-1:0]   ld;   // lookahead divisor

    logic [W2-1:0]   dd;
    logic [W2-1:0]   pwc;
    logic [W2-1:0]   lcd;
    logic [NW-1:0]   c_mod;
    logic [LW-1:0]   lc_mod;

    // Products are formed at double width so the comparisons against lim never overflow.
    always_comb begin
        dd     = W2'(d) * W2'(d);
        pwc    = W2'(pw) * W2'(c);
        lcd    = W2'(ld) * W2'(ld);
        c_mod  = c % d;
        lc_mod = lc % LW'(ld);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            lim              <= '0;
            c                <= '0;
            d                <= '0;
            pw               <= '0;
            lc               <= '0;
            ld               <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            out_if.out_last  <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            count            <= '0;
`ifdef PRIME_POWER_LCM_EN
            lcm              <= WIDTH'(1);
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lim   <= n;
                        count <= '0;
                        c     <= NW'(2);
                        d     <= NW'(2);
`ifdef PRIME_POWER_LCM_EN
                        lcm   <= WIDTH'(1);
`endif
                        if (n < NW'(2)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= TEST;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end

                TEST: begin
                    if (dd > W2'(c)) begin
                        pw    <= c;
                        state <= POWER;
                    end else if (c_mod == '0) begin
                        // Composite; if it was lim, no primes remain (only reachable for composite lim).
                        if (c == lim) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            c <= c + NW'(1);
                            d <= NW'(2);
                        end
                    end else begin
                        d <= d + NW'(1);
                    end
                end

                POWER: begin
                    if (pwc <= W2'(lim)) begin
                        pw <= pwc[NW-1:0];
                    end else begin
                        state <= EMIT;
                        lc    <= LW'(c) + LW'(1);
                        ld    <= NW'(2);
                    end
                end

                EMIT: begin
                    if (!out_if.out_valid) begin
                        // Search (c, lim] for another prime before raising valid, so out_last
                        // is already correct on the first valid cycle.
                        if (lc > LW'(lim)) begin
                            out_if.out_valid <= 1'b1;
                            out_if.out_data  <= WIDTH'(pw);
                            out_if.out_last  <= 1'b1;
                        end else if (lcd > W2'(lc)) begin
                            out_if.out_valid <= 1'b1;
                            out_if.out_data  <= WIDTH'(pw);
                            out_if.out_last  <= 1'b0;
                        end else if (lc_mod == '0) begin
                            lc <= lc + LW'(1);
                            ld <= NW'(2);
                        end else begin
                            ld <= ld + NW'(1);
                        end
                    end else if (out_if.out_ready) begin
                        // Transfer; valid drops next cycle and cannot re-rise until the next EMIT.
                        out_if.out_valid <= 1'b0;
                        count            <= count + NW'(1);
`ifdef PRIME_POWER_LCM_EN
                        lcm              <= lcm * out_if.out_data;
`endif
                        if (out_if.out_last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            c     <= c + NW'(1);
                            d     <= NW'(2);
                            state <= TEST;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prime_power_gen.sv
module tb_prime_power_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] n = 8'd0;
    logic       busy;
    logic       done;
    logic [7:0] count;
`ifdef PRIME_POWER_LCM_EN
    logic [31:0] lcm;
`endif

    int checks = 0;
    int errors = 0;

    int got_d[$];
    int got_l[$];
    int exp_q[$];

    prime_power_gen_if #(.WIDTH(32)) bus ();

    prime_power_gen #(.NW(8), .WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .n      (n),
        .out_if (bus),
        .busy   (busy),
        .done   (done),
`ifdef PRIME_POWER_LCM_EN
        .lcm    (lcm),
`endif
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start, then watch the stream until done. mode 0: ready always high,
    // mode 1: ready random. inject >= 0 pulses start with n=5 at that cycle.
    task automatic run(input logic [7:0] nn, input int mode, input int inject);
        bit   prev_stall = 0;
        logic [31:0] prev_d = '0;
        logic prev_l = 1'b0;
        bit   finished = 0;
        got_d.delete();
        got_l.delete();
        @(negedge clk);
        start = 1'b1;
        n     = nn;
        @(negedge clk);
        start = 1'b0;
        if (nn >= 8'd2) chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int cyc = 0; cyc < 8000; cyc++) begin
            if (cyc == inject) begin
                start = 1'b1;
                n     = 8'd5;
            end else begin
                start = 1'b0;
            end
            bus.out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (prev_stall)
                chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_data[29:0]},
                    {1'b1, prev_l, prev_d[29:0]});
            if (bus.out_valid && bus.out_ready) begin
                got_d.push_back(int'(bus.out_data));
                got_l.push_back(int'(bus.out_last));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d     = bus.out_data;
            prev_l     = bus.out_last;
            if (done) begin
                finished = 1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_finished", {31'd0, finished}, 32'd1);
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_nbeats"}, got_d.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_q[i]);
            chk($sformatf("%s_last%0d", tag, i), got_l[i], (i == exp_q.size() - 1) ? 1 : 0);
        end
        chk({tag, "_count"}, {24'd0, count}, exp_q.size());
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_lcm(input string tag, input logic [31:0] exp);
`ifdef PRIME_POWER_LCM_EN
        chk({tag, "_lcm"}, lcm, exp);
`else
        if (exp == 32'd0) chk({tag, "_lcm_absent"}, 32'd0, 32'd1);
`endif
    endtask

    initial begin
        bus.out_ready = 1'b1;
        #12;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_last", {31'd0, bus.out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_count", {24'd0, count}, 32'd0);
        check_lcm("rst", 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // n=20, free-flowing
        exp_q = '{16, 9, 5, 7, 11, 13, 17, 19};
        run(8'd20, 0, -1);
        check_beats("n20");
        check_lcm("n20", 32'd232792560);

        // n=10 with random backpressure
        exp_q = '{8, 9, 5, 7};
        run(8'd10, 1, -1);
        check_beats("n10");
        check_lcm("n10", 32'd2520);

        // degenerate limits
        exp_q = {};
        run(8'd1, 0, -1);
        check_beats("n1");
        check_lcm("n1", 32'd1);
        run(8'd0, 0, -1);
        check_beats("n0");
        check_lcm("n0", 32'd1);

        exp_q = '{2};
        run(8'd2, 0, -1);
        check_beats("n2");
        check_lcm("n2", 32'd2);

        // composite tail after last prime
        exp_q = '{16, 9, 5, 7, 11, 13};
        run(8'd16, 0, -1);
        check_beats("n16");
        check_lcm("n16", 32'd720720);

        // start while busy must be ignored
        exp_q = '{16, 9, 5, 7, 11, 13, 17, 19};
        run(8'd20, 0, 30);
        check_beats("restart_ignored");
        check_lcm("restart_ignored", 32'd232792560);

        // reset while a beat is stalled in EMIT
        @(negedge clk);
        bus.out_ready = 1'b0;
        start = 1'b1;
        n     = 8'd20;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && !bus.out_valid; i++) @(negedge clk);
        chk("emit_reached", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_data", bus.out_data, 32'd0);
        chk("midrst_last", {31'd0, bus.out_last}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_count", {24'd0, count}, 32'd0);
        check_lcm("midrst", 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        exp_q = '{4, 3, 5};
        run(8'd6, 0, -1);
        check_beats("n6");
        check_lcm("n6", 32'd60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prime_power_gen.md
Name: prime_power_gen

Overview:
- Upstream feeder for the Euler #5 product stage.
- For an input limit n, it finds every prime p <= n, in ascending order.
- For each prime it computes the largest power p^k <= n and streams it out over a valid/ready handshake.
- The downstream multiplier consumes these values. Their product is lcm(1..n); for n=20 the stream is 16, 9, 5, 7, 11, 13, 17, 19.

Parameters:
- NW, 8, width of limit n and of internal candidate/divisor/power registers.
- WIDTH, 32, width of out_data (value zero-extended from NW bits) and of optional lcm.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE or DONE.
- n  input  NW  limit; captured on accepted start.
- out_ready  input  1  downstream accepts a beat when out_valid & out_ready.
- out_valid  output  1  out_data holds a valid prime power.
- out_data  output  WIDTH  largest power of current prime <= n.
- out_last  output  1  high with the final beat of a run.
- busy  output  1  high from accepted start until DONE.
- done  output  1  level; high in DONE until the next accepted start or reset.
- count  output  NW  number of beats transferred in the current/last run.

Behaviour:
- Reset (async, rst_n low) clears all state. State=IDLE; out_valid=0, out_data=0, out_last=0, busy=0, done=0, count=0.
- States are IDLE, TEST, POWER, EMIT, DONE.
- IDLE/DONE, start=1:
  - Latch n into lim, clear count and done, set busy.
  - Candidate c=2, divisor d=2.
  - If lim<2, go directly to DONE with count=0 and no beats.
  - Otherwise go to TEST.
- TEST: one divisor per cycle.
  - If d*d > c, c is prime: load pw=c and go to POWER.
  - Else if c mod d == 0, c is composite: advance.
  - Else d<=d+1.
  - Advance means c<=c+1, d<=2. If c==lim, go to DONE without emitting; this cannot happen if lim itself is prime.
- POWER: one multiply per cycle.
  - If pw*c <= lim (computed at 2*NW bits, no overflow), pw<=pw*c.
  - Else go to EMIT: present out_valid=1, out_data=pw, out_last=1 iff no prime exists in (c, lim].
- out_last computation:
  - out_last is determined in EMIT by a pre-scan or by a lookahead search before asserting valid.
  - The implementation choice is free, but out_last must be correct on the first cycle out_valid is high.
- EMIT handshake:
  - out_data and out_last are held stable while out_valid & !out_ready.
  - On a transfer, count<=count+1 and out_valid drops the next cycle.
  - If out_last was set, go to DONE. Otherwise c<=c+1, d<=2, and go to TEST.
  - out_valid must never rise while in the same cycle as a transfer completing: there is at most one beat per EMIT entry.
- DONE: busy=0, done=1, out_valid=0. Remain until start.
- start while busy is ignored: no restart, no latch of n.
- Reset mid-run aborts immediately, with no partial beat. After reset, a new start behaves normally.
- Primes are emitted strictly ascending, each exactly once.
- Values are always <= lim < 2^NW, so they are zero-extended to WIDTH.
- Latency is not fixed. It is bounded by (lim^1.5 + lim*log2(lim) + beats) cycles plus backpressure stalls.

Optional Feature:
- PRIME_POWER_LCM_EN defined:
  - Adds output port lcm [WIDTH-1:0].
  - lcm is cleared to 1 on accepted start and multiplied by out_data on each transfer, truncated modulo 2^WIDTH.
  - lcm is valid when done=1. Reset value is 1. Run with n<2 gives lcm=1.
- Undefined: port lcm and accumulator are absent; all other behaviour is identical.

Test Plan:
- start with n=20, out_ready=1 -> beats 16,9,5,7,11,13,17,19; out_last only on 19; count=8; done=1; lcm=232792560 if PRIME_POWER_LCM_EN.
- n=10, out_ready toggled pseudo-randomly -> beats 8,9,5,7 with out_data/out_last stable during stalls; count=4; lcm=2520.
- n=1 and n=0 -> no out_valid ever; done=1 with count=0; lcm=1. n=2 -> single beat 2 with out_last=1; count=1.
- n=16 -> last prime 13; out_last on beat 13 (values 16,9,5,7,11,13); no beat for composite 14..16.
- Second start pulse mid-run (n=5) -> ignored; run completes with n=20 results. rst_n low during EMIT with out_ready=0 -> all outputs to reset values immediately; subsequent start n=6 -> beats 4,3,5, count=3.
